// File: rtl/vx_stream_rr_mux.sv
// vx_stream_rr_mux: round-robin N:1 valid/ready stream mux, optional output register.
// Define VX_STREAM_RR_MUX_PERF_EN to add the perf_stalls/perf_xfers counters.
module vx_stream_rr_mux #(
  parameter int NUM_REQS = 4,
  parameter int DATAW = 32,
  parameter int OUT_BUF = 1,
  localparam int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic [LOG_NUM_REQS-1:0]   sel_out,
  input  logic                      ready_out
`ifdef VX_STREAM_RR_MUX_PERF_EN
  ,
  output logic [43:0]               perf_stalls,
  output logic [43:0]               perf_xfers
`endif
);

  typedef logic [LOG_NUM_REQS-1:0] idx_t;

  logic [DATAW-1:0] din [NUM_REQS];

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_din
    assign din[i] = data_in[i*DATAW +: DATAW];
  end

  idx_t rr_ptr_q, rr_ptr_d;
  idx_t rr_grant, grant;
  logic rr_valid, grant_valid;
  logic in_xfer;
  logic [NUM_REQS-1:0] grant_oh;

  function automatic idx_t next_idx(idx_t g);
    return (g == idx_t'(NUM_REQS - 1)) ? '0 : g + idx_t'(1);
  endfunction

  // Scan from the far end so the lowest offset from rr_ptr wins.
  always_comb begin
    int j;
    rr_valid = 1'b0;
    rr_grant = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_REQS) j = j - NUM_REQS;
      if (valid_in[idx_t'(j)]) begin
        rr_valid = 1'b1;
        rr_grant = idx_t'(j);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      grant_oh[i] = (grant == idx_t'(i));
    end
  end

  assign in_xfer  = |(valid_in & ready_in);
  assign rr_ptr_d = in_xfer ? next_idx(grant) : rr_ptr_q;

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  if (OUT_BUF == 0) begin : g_comb
    logic lock_q, lock_d;
    idx_t lock_idx_q, lock_idx_d;

    // A stalled output pins its source; a dropped source frees the lock.
    always_comb begin
      grant       = rr_grant;
      grant_valid = rr_valid;
      if (lock_q) begin
        grant       = lock_idx_q;
        grant_valid = valid_in[lock_idx_q];
      end
    end

    assign valid_out = grant_valid & ~reset;
    assign data_out  = din[grant];
    assign sel_out   = grant;
    assign ready_in  = grant_oh
                     & {NUM_REQS{grant_valid & ready_out & ~reset}};

    always_comb begin
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (lock_q) begin
        if (!grant_valid || ready_out) lock_d = 1'b0;
      end else if (valid_out && !ready_out) begin
        lock_d     = 1'b1;
        lock_idx_d = grant;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        lock_q     <= 1'b0;
        lock_idx_q <= '0;
      end else begin
        lock_q     <= lock_d;
        lock_idx_q <= lock_idx_d;
      end
    end
  end else begin : g_reg
    logic             valid_q, valid_d;
    logic [DATAW-1:0] data_q, data_d;
    idx_t             sel_q, sel_d;
    logic             accept;

    assign grant       = rr_grant;
    assign grant_valid = rr_valid;
    assign accept      = ~valid_q | ready_out;
    assign ready_in    = grant_oh
                       & {NUM_REQS{grant_valid & accept & ~reset}};

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      sel_d   = sel_q;
      if (in_xfer) begin
        valid_d = 1'b1;
        data_d  = din[grant];
        sel_d   = grant;
      end else if (ready_out) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        sel_q   <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        sel_q   <= sel_d;
      end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign sel_out   = sel_q;
  end

`ifdef VX_STREAM_RR_MUX_PERF_EN
  logic [43:0] stalls_q, xfers_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stalls_q <= '0;
      xfers_q  <= '0;
    end else begin
      if ((|valid_in) && !in_xfer) stalls_q <= stalls_q + 44'd1;
      if (valid_out && ready_out)  xfers_q  <= xfers_q + 44'd1;
    end
  end

  assign perf_stalls = stalls_q;
  assign perf_xfers  = xfers_q;
`endif

endmodule

// File: tb/tb_vx_stream_rr_mux.sv
// Bench for vx_stream_rr_mux: combinational (u0) and registered (u1) instances
// on shared stimulus; u1 is tracked by a grant model feeding a scoreboard.
module tb_vx_stream_rr_mux;
  localparam int N = 4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] valid_in = '0;
  logic [N*W-1:0] data_in = '0;
  logic         ready_out = 1'b0;

  logic [N-1:0] rdy0, rdy1;
  logic         v0, v1;
  logic [W-1:0] d0, d1;
  logic [1:0]   s0, s1;
`ifdef VX_STREAM_RR_MUX_PERF_EN
  logic [43:0]  ps0, px0, ps1, px1;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vx_stream_rr_mux #(.NUM_REQS(N), .DATAW(W), .OUT_BUF(0)) u0 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .ready_in(rdy0), .valid_out(v0), .data_out(d0), .sel_out(s0),
    .ready_out(ready_out)
`ifdef VX_STREAM_RR_MUX_PERF_EN
    , .perf_stalls(ps0), .perf_xfers(px0)
`endif
  );

  vx_stream_rr_mux #(.NUM_REQS(N), .DATAW(W), .OUT_BUF(1)) u1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .ready_in(rdy1), .valid_out(v1), .data_out(d1), .sel_out(s1),
    .ready_out(ready_out)
`ifdef VX_STREAM_RR_MUX_PERF_EN
    , .perf_stalls(ps1), .perf_xfers(px1)
`endif
  );

  typedef struct {
    int         sel;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   m_ptr = 0;
  bit   m_valid = 1'b0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] lane(int i);
    return data_in[i*W +: W];
  endfunction

  task automatic drive(bit r, logic [N-1:0] v, bit ro);
    @(posedge clk);
    #1;
    reset     = r;
    valid_in  = v;
    ready_out = ro;
  endtask

  task automatic setdata(int seed);
    for (int i = 0; i < N; i++) data_in[i*W +: W] = W'(seed * 16 + i);
  endtask

  // Registered-instance model: compare output first, then predict the accept.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_rdy0", 64'(rdy0), 64'd0);
      check("rst_rdy1", 64'(rdy1), 64'd0);
      m_valid = 1'b0;
      m_ptr   = 0;
      sb.delete();
    end else begin
      exp_t         e;
      int           g;
      bit           acc;
      logic [N-1:0] er;
      check("sb_valid", 64'(v1), 64'(m_valid));
      if (m_valid && ready_out && sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_sel", 64'(s1), 64'(e.sel));
        check("sb_data", 64'(d1), 64'(e.data));
      end
      g = 0;
      for (int k = N - 1; k >= 0; k--) begin
        if (valid_in[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      acc = !m_valid || ready_out;
      er  = ((|valid_in) && acc) ? (N'(1) << g) : '0;
      check("sb_ready", 64'(rdy1), 64'(er));
      if ((|valid_in) && acc) begin
        sb.push_back('{g, lane(g)});
        m_ptr   = (g + 1) % N;
        m_valid = 1'b1;
      end else if (ready_out) begin
        m_valid = 1'b0;
      end
    end
  end

  initial begin
    logic [W-1:0] hold1;
    logic [W-1:0] a_dat;
    logic [W-1:0] b_dat;

    valid_in  = 4'b1111;
    ready_out = 1'b1;
    setdata(0);
    repeat (2) begin
      @(negedge clk);
      check("rst_v0", 64'(v0), 64'd0);
      check("rst_v1", 64'(v1), 64'd0);
    end

    for (int k = 0; k < 8; k++) begin
      drive(0, 4'b1111, 1);
      setdata(k + 1);
      @(negedge clk);
      check("fair_sel0", 64'(s0), 64'(k % 4));
      check("fair_rdy0", 64'(rdy0), 64'(1 << (k % 4)));
      check("fair_dat0", 64'(d0), 64'(lane(k % 4)));
      if (k == 0) check("first_rdy1", 64'(rdy1), 64'b0001);
      else        check("fair_sel1", 64'(s1), 64'((k - 1) % 4));
    end

    for (int j = 0; j < 4; j++) begin
      drive(0, 4'b1010, 1);
      setdata(20 + j);
      @(negedge clk);
      check("skip_sel0", 64'(s0), (j % 2) ? 64'd3 : 64'd1);
      if (j > 0) check("skip_sel1", 64'(s1), (j % 2) ? 64'd1 : 64'd3);
    end

    drive(1, 4'b0000, 0);
    @(negedge clk);
    drive(0, 4'b0110, 0);
    setdata(40);
    hold1 = lane(1);
    @(negedge clk);
    check("lock_v0", 64'(v0), 64'd1);
    check("lock_sel0", 64'(s0), 64'd1);
    check("lock_rdy0", 64'(rdy0), 64'd0);
    for (int c = 1; c < 5; c++) begin
      drive(0, 4'b0111, 0);
      data_in[0*W +: W] = W'(c);
      data_in[2*W +: W] = W'(c + 100);
      @(negedge clk);
      check("lock_sel0", 64'(s0), 64'd1);
      check("lock_dat0", 64'(d0), 64'(hold1));
      check("lock_rdy0", 64'(rdy0), 64'd0);
    end
    drive(0, 4'b0111, 1);
    @(negedge clk);
    check("unlock_rdy0", 64'(rdy0), 64'b0010);
    check("unlock_dat0", 64'(d0), 64'(hold1));
    drive(0, 4'b0111, 1);
    @(negedge clk);
    check("next_sel0", 64'(s0), 64'd2);
    check("next_rdy0", 64'(rdy0), 64'b0100);

    drive(1, 4'b0000, 0);
    @(negedge clk);
    drive(0, 4'b0001, 0);
    a_dat = 32'hA0A0_0001;
    b_dat = 32'hB0B0_0002;
    data_in[0*W +: W] = a_dat;
    @(negedge clk);
    check("sim_rdyA", 64'(rdy1), 64'b0001);
    drive(0, 4'b0100, 1);
    data_in[2*W +: W] = b_dat;
    @(negedge clk);
    check("sim_vA", 64'(v1), 64'd1);
    check("sim_selA", 64'(s1), 64'd0);
    check("sim_datA", 64'(d1), 64'(a_dat));
    check("sim_rdyB", 64'(rdy1), 64'b0100);
    drive(0, 4'b0000, 1);
    @(negedge clk);
    check("sim_vB", 64'(v1), 64'd1);
    check("sim_selB", 64'(s1), 64'd2);
    check("sim_datB", 64'(d1), 64'(b_dat));
    drive(0, 4'b0000, 1);
    @(negedge clk);
    check("drain_v", 64'(v1), 64'd0);
    check("drain_hold", 64'(d1), 64'(b_dat));

`ifdef VX_STREAM_RR_MUX_PERF_EN
    drive(1, 4'b0000, 1);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      drive(0, 4'b1111, 1);
      setdata(60 + i);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'b1111, 0);
      @(negedge clk);
    end
    drive(0, 4'b0000, 1);
    @(negedge clk);
    drive(0, 4'b0001, 0);
    @(negedge clk);
    check("perf_xfers", 64'(px1), 64'd10);
    check("perf_stalls", 64'(ps1), 64'd3);
    drive(1, 4'b0000, 0);
    @(negedge clk);
    check("prst_full", 64'(v1), 64'd1);
    drive(0, 4'b0000, 0);
    @(negedge clk);
    check("prst_v", 64'(v1), 64'd0);
    check("prst_xfers", 64'(px1), 64'd0);
    check("prst_stalls", 64'(ps1), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
